uart_tx_ctrl: RTL and testbench

UART transmit controller and serializer. It sits directly upstream of the TX output multiplexer/register stage. The block accepts a parallel byte with a valid strobe and sequences a frame: start, data LSB-first, optional parity, stop. It drives the mux select, serial data bit, parity bit and busy flag consumed by the output stage.

---
 rtl/uart_tx_ctrl_if.sv | 23 ++
 rtl/uart_tx_ctrl.sv | 111 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Parallel-side handshake and frame-field outputs of the UART TX controller.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  mux_sel, ser_data, par_bit, busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output mux_sel, ser_data, par_bit, busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// All outputs are registered; a new byte is accepted in IDLE or STOP, giving gapless back-to-back frames.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_ctrl_if.slave  bus
);

  localparam int            CW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic [1:0]    SEL_START = 2'b00;
  localparam logic [1:0]    SEL_STOP  = 2'b01;
  localparam logic [1:0]    SEL_DATA  = 2'b10;
  localparam logic [1:0]    SEL_PAR   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic [1:0]            r_mux_sel;
  logic                  r_ser_data;
  logic                  r_par_bit;
  logic                  r_busy;

  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_par_in;

  assign w_cnt_nxt = r_cnt + 1'b1;
  // Parity is resolved at acceptance so it stays constant for the whole frame.
  assign w_par_in  = (^bus.P_DATA) ^ bus.PAR_TYP;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_mux_sel  <= SEL_STOP;
      r_ser_data <= 1'b0;
      r_par_bit  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_STOP: begin
          r_ser_data <= 1'b0;
          if (bus.DATA_VALID) begin
            r_state   <= S_START;
            r_cnt     <= '0;
            r_data    <= bus.P_DATA;
            r_par_en  <= bus.PAR_EN;
            r_par_bit <= w_par_in;
            r_mux_sel <= SEL_START;
            r_busy    <= 1'b1;
          end else begin
            r_state   <= S_IDLE;
            r_mux_sel <= SEL_STOP;
            r_busy    <= 1'b0;
          end
        end
        S_START: begin
          r_state    <= S_DATA;
          r_cnt      <= '0;
          r_mux_sel  <= SEL_DATA;
          r_ser_data <= r_data[0];
        end
        S_DATA: begin
          if (r_cnt == LAST_BIT) begin
            r_cnt      <= '0;
            r_ser_data <= 1'b0;
            if (r_par_en) begin
              r_state   <= S_PARITY;
              r_mux_sel <= SEL_PAR;
            end else begin
              r_state   <= S_STOP;
              r_mux_sel <= SEL_STOP;
            end
          end else begin
            r_cnt      <= w_cnt_nxt;
            r_ser_data <= r_data[w_cnt_nxt];
          end
        end
        S_PARITY: begin
          r_state   <= S_STOP;
          r_mux_sel <= SEL_STOP;
        end
        default: begin
          r_state    <= S_IDLE;
          r_mux_sel  <= SEL_STOP;
          r_ser_data <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux_sel  = r_mux_sel;
  assign bus.ser_data = r_ser_data;
  assign bus.par_bit  = r_par_bit;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomised and directed bench for uart_tx_ctrl against a per-cycle frame model.
module tb_uart_tx_ctrl;
  localparam int W = 8;

  logic CLK;
  logic RST;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  uart_tx_ctrl_if #(.DATA_WIDTH(W)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int   exp_mux[$];
  logic exp_ser[$];
  logic exp_busy[$];
  logic exp_par[$];
  int   obs_mux[$];
  logic obs_ser[$];
  logic obs_busy[$];
  logic obs_par[$];

  function automatic void clear_q();
    exp_mux.delete(); exp_ser.delete(); exp_busy.delete(); exp_par.delete();
    obs_mux.delete(); obs_ser.delete(); obs_busy.delete(); obs_par.delete();
  endfunction

  function automatic void push_exp(input int m, input logic s, input logic b, input logic p);
    exp_mux.push_back(m);
    exp_ser.push_back(s);
    exp_busy.push_back(b);
    exp_par.push_back(p);
  endfunction

  // One expected entry per UART bit time, derived from the frame format.
  function automatic void model_frame(input logic [W-1:0] d, input logic pe, input logic pt);
    int   ones;
    logic p;
    ones = 0;
    for (int i = 0; i < W; i++) ones += int'(d[i]);
    p = ((ones % 2) == 1) ^ pt;
    push_exp(0, 1'b0, 1'b1, p);
    for (int i = 0; i < W; i++) push_exp(2, d[i], 1'b1, p);
    if (pe) push_exp(3, 1'b0, 1'b1, p);
    push_exp(1, 1'b0, 1'b1, p);
  endfunction

  function automatic void push_idle();
    push_exp(1, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic sample();
    obs_mux.push_back(int'(bus.mux_sel));
    obs_ser.push_back(bus.ser_data);
    obs_busy.push_back(bus.busy);
    obs_par.push_back(bus.par_bit);
  endtask

  // Pulse DATA_VALID for one cycle, scramble inputs afterwards, record n cycles.
  task automatic capture(input logic [W-1:0] d, input logic pe, input logic pt, input int n);
    @(negedge CLK);
    bus.P_DATA = d; bus.PAR_EN = pe; bus.PAR_TYP = pt; bus.DATA_VALID = 1'b1;
    @(negedge CLK);
    bus.DATA_VALID = 1'b0;
    bus.P_DATA  = W'($urandom);
    bus.PAR_EN  = 1'($urandom);
    bus.PAR_TYP = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      sample();
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    bus.DATA_VALID = 1'b1; bus.P_DATA = 8'hFF; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      cmp_cnt++;
      if ({bus.mux_sel, bus.ser_data, bus.par_bit, bus.busy} !== 5'b01000) begin
        err_cnt++;
        $display("FAIL reset_hold cyc%0d: got mux=%b ser=%b par=%b busy=%b, want 01 0 0 0",
                 i, bus.mux_sel, bus.ser_data, bus.par_bit, bus.busy);
      end
    end
    bus.DATA_VALID = 1'b0;
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      cmp_cnt++;
      if (bus.mux_sel !== 2'b01 || bus.busy !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_release cyc%0d: got mux=%b busy=%b, want 01 0", i, bus.mux_sel, bus.busy);
      end
    end
  endtask

  task automatic test_parity_frames();
    logic [W-1:0] td[4]   = '{8'hA5, 8'hA5, 8'h01, 8'h3C};
    logic         tpe[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic         tpt[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    int           tlen[4] = '{11, 11, 11, 10};
    logic         tpar[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int           nbusy;
    for (int t = 0; t < 4; t++) begin
      clear_q();
      model_frame(td[t], tpe[t], tpt[t]);
      push_idle();
      capture(td[t], tpe[t], tpt[t], exp_mux.size());
      for (int i = 0; i < exp_mux.size(); i++) begin
        cmp_cnt++;
        if (obs_mux[i] !== exp_mux[i] || obs_busy[i] !== exp_busy[i]) begin
          err_cnt++;
          $display("FAIL frame%0d cyc%0d mux/busy: got %0d/%b want %0d/%b",
                   t, i, obs_mux[i], obs_busy[i], exp_mux[i], exp_busy[i]);
        end
        if (exp_mux[i] == 2) begin
          cmp_cnt++;
          if (obs_ser[i] !== exp_ser[i]) begin
            err_cnt++;
            $display("FAIL frame%0d cyc%0d ser: got %b want %b", t, i, obs_ser[i], exp_ser[i]);
          end
        end
        if (exp_busy[i]) begin
          cmp_cnt++;
          if (obs_par[i] !== exp_par[i]) begin
            err_cnt++;
            $display("FAIL frame%0d cyc%0d par: got %b want %b", t, i, obs_par[i], exp_par[i]);
          end
        end
      end
      nbusy = 0;
      foreach (obs_busy[i]) nbusy += int'(obs_busy[i]);
      cmp_cnt++;
      if (nbusy != tlen[t]) begin
        err_cnt++;
        $display("FAIL frame%0d busy_len: got %0d want %0d", t, nbusy, tlen[t]);
      end
      if (tpe[t]) begin
        cmp_cnt++;
        if (obs_par[1] !== tpar[t]) begin
          err_cnt++;
          $display("FAIL frame%0d par_const: got %b want %b", t, obs_par[1], tpar[t]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int l1;
    clear_q();
    model_frame(8'h5A, 1'b1, 1'b0);
    l1 = exp_mux.size();
    model_frame(8'hFF, 1'b1, 1'b0);
    push_idle();
    @(negedge CLK);
    bus.P_DATA = 8'h5A; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.DATA_VALID = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < exp_mux.size(); i++) begin
      sample();
      if (i == 3) bus.P_DATA = 8'hFF;
      if (i == l1) bus.DATA_VALID = 1'b0;
      @(negedge CLK);
    end
    for (int i = 0; i < exp_mux.size(); i++) begin
      cmp_cnt++;
      if (obs_mux[i] !== exp_mux[i] || obs_busy[i] !== exp_busy[i]) begin
        err_cnt++;
        $display("FAIL b2b cyc%0d mux/busy: got %0d/%b want %0d/%b",
                 i, obs_mux[i], obs_busy[i], exp_mux[i], exp_busy[i]);
      end
      if (exp_mux[i] == 2) begin
        cmp_cnt++;
        if (obs_ser[i] !== exp_ser[i]) begin
          err_cnt++;
          $display("FAIL b2b cyc%0d ser: got %b want %b", i, obs_ser[i], exp_ser[i]);
        end
      end
      if (exp_busy[i]) begin
        cmp_cnt++;
        if (obs_par[i] !== exp_par[i]) begin
          err_cnt++;
          $display("FAIL b2b cyc%0d par: got %b want %b", i, obs_par[i], exp_par[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge CLK);
    bus.P_DATA = 8'h96; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.DATA_VALID = 1'b1;
    @(negedge CLK);
    bus.DATA_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    cmp_cnt++;
    if (bus.mux_sel !== 2'b10 || bus.busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL mid_reset_pre: got mux=%b busy=%b want 10 1", bus.mux_sel, bus.busy);
    end
    RST = 1'b0;
    #1;
    cmp_cnt++;
    if ({bus.mux_sel, bus.ser_data, bus.par_bit, bus.busy} !== 5'b01000) begin
      err_cnt++;
      $display("FAIL mid_reset_async: got mux=%b ser=%b par=%b busy=%b want 01 0 0 0",
               bus.mux_sel, bus.ser_data, bus.par_bit, bus.busy);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      cmp_cnt++;
      if (bus.mux_sel !== 2'b01 || bus.busy !== 1'b0) begin
        err_cnt++;
        $display("FAIL mid_reset_idle cyc%0d: got mux=%b busy=%b want 01 0", i, bus.mux_sel, bus.busy);
      end
    end
    clear_q();
    model_frame(8'hC3, 1'b1, 1'b1);
    push_idle();
    capture(8'hC3, 1'b1, 1'b1, exp_mux.size());
    for (int i = 0; i < exp_mux.size(); i++) begin
      cmp_cnt++;
      if (obs_mux[i] !== exp_mux[i] || obs_busy[i] !== exp_busy[i] ||
          (exp_mux[i] == 2 && obs_ser[i] !== exp_ser[i]) ||
          (exp_busy[i] && obs_par[i] !== exp_par[i])) begin
        err_cnt++;
        $display("FAIL after_reset cyc%0d: got mux=%0d busy=%b ser=%b par=%b want %0d %b %b %b",
                 i, obs_mux[i], obs_busy[i], obs_ser[i], obs_par[i],
                 exp_mux[i], exp_busy[i], exp_ser[i], exp_par[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    logic         pe;
    logic         pt;
    for (int f = 0; f < 25; f++) begin
      d  = W'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      clear_q();
      model_frame(d, pe, pt);
      push_idle();
      capture(d, pe, pt, exp_mux.size());
      for (int i = 0; i < exp_mux.size(); i++) begin
        cmp_cnt++;
        if (obs_mux[i] !== exp_mux[i] || obs_busy[i] !== exp_busy[i] ||
            (exp_mux[i] == 2 && obs_ser[i] !== exp_ser[i]) ||
            (exp_busy[i] && obs_par[i] !== exp_par[i])) begin
          err_cnt++;
          $display("FAIL rand f%0d d=%h pe=%b pt=%b cyc%0d: got mux=%0d busy=%b ser=%b par=%b want %0d %b %b %b",
                   f, d, pe, pt, i, obs_mux[i], obs_busy[i], obs_ser[i], obs_par[i],
                   exp_mux[i], exp_busy[i], exp_ser[i], exp_par[i]);
        end
      end
    end
  endtask

  initial begin
    bus.P_DATA = '0; bus.DATA_VALID = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    test_reset();
    test_parity_frames();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
